// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// register-index width and the DMEM wait FSM states.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_forward.sv
// Forwarding compare for one E-stage source operand against the M and W
// producers.
module hazard_forward_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rs_e,
    input  logic [REG_W-1:0] rd_m,
    input  logic [REG_W-1:0] rd_w,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    output logic [1:0]       fwd_sel
);

    // Select the youngest in-flight producer of rs_e; x0 is never forwarded
    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
            fwd_sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            fwd_sel = FWD_WB;
        end else begin
            fwd_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: operand forwarding, load-use
// stalls, branch flushes, DMEM wait freeze with timeout, stall-cycle counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             dmem_ready,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FreezeEMW,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_ZERO = {WCNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    hz_state_e         state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;
    logic       lw_stall_s;
    logic       mem_wait_s;
    logic       timeout_s;

    hazard_forward_unit u_fwd_a (
        .rs_e        (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (fwd_a_s)
    );

    hazard_forward_unit u_fwd_b (
        .rs_e        (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd_sel     (fwd_b_s)
    );

    assign lw_stall_s = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // DMEM wait FSM: freeze while not ready, give up after MEM_TIMEOUT cycles
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        mem_wait_s = 1'b0;
        timeout_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MemReqM && !dmem_ready) begin
                    mem_wait_s = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wcnt_d     = WCNT_ONE;
                end else begin
                    state_d = ST_IDLE;
                    wcnt_d  = WCNT_ZERO;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = ST_IDLE;
                    wcnt_d  = WCNT_ZERO;
                end else if (wcnt_q == WCNT_LAST) begin
                    // Forced release: the pipeline advances and the error is flagged
                    timeout_s = 1'b1;
                    state_d   = ST_IDLE;
                    wcnt_d    = WCNT_ZERO;
                end else begin
                    mem_wait_s = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wcnt_d     = wcnt_q + WCNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wcnt_d  = WCNT_ZERO;
            end
        endcase
    end

    // Output priority: reset, then DMEM freeze, then load-use / branch
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FreezeEMW = 1'b0;
        if (rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (mem_wait_s) begin
            ForwardAE = fwd_a_s;
            ForwardBE = fwd_b_s;
            StallF    = 1'b1;
            StallD    = 1'b1;
            FreezeEMW = 1'b1;
        end else begin
            ForwardAE = fwd_a_s;
            ForwardBE = fwd_b_s;
            StallF    = lw_stall_s;
            StallD    = lw_stall_s;
            FlushD    = PCSrcE;
            FlushE    = lw_stall_s | PCSrcE;
        end
    end

    // Next values of the error pulse and the free-running stall counter
    always_comb begin
        mem_err_d = timeout_s;
        if (StallF) begin
            stall_cycles_d = stall_cycles_q + CNT_ONE;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // State, wait counter, error pulse and stall counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            wcnt_q         <= WCNT_ZERO;
            mem_err_q      <= 1'b0;
            stall_cycles_q <= {CNT_W{1'b0}};
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            mem_err_q      <= mem_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run against a behavioural reference model.
module tb_pipeline_hazard_ctrl;

    localparam int T  = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, dmem_ready;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, FlushD, FlushE, FreezeEMW, mem_err;
    logic [CW-1:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    // Reference model: waited cycles of the outstanding access, expected registered outputs
    int            m_p   = 0;
    bit            m_err = 1'b0;
    logic [CW-1:0] m_cnt = '0;
    logic [1:0]    e_fa, e_fb;
    logic          e_sf, e_sd, e_fd, e_fe, e_frz;
    bit            e_to;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .dmem_ready(dmem_ready),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .FreezeEMW(FreezeEMW), .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_comb();
        bit lw, active, frz;
        lw     = ResultSrcE0 && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
        active = (m_p > 0) || MemReqM;
        frz    = active && !dmem_ready && (m_p + 1 < T);
        e_to   = active && !dmem_ready && (m_p + 1 >= T);
        if (rst) begin
            e_fa = 2'b00; e_fb = 2'b00;
            e_sf = 1'b0; e_sd = 1'b0; e_fd = 1'b1; e_fe = 1'b1; e_frz = 1'b0;
            e_to = 1'b0; frz = 1'b0;
        end else if (frz) begin
            e_fa = ref_fwd(Rs1E); e_fb = ref_fwd(Rs2E);
            e_sf = 1'b1; e_sd = 1'b1; e_fd = 1'b0; e_fe = 1'b0; e_frz = 1'b1;
        end else begin
            e_fa = ref_fwd(Rs1E); e_fb = ref_fwd(Rs2E);
            e_sf = lw; e_sd = lw; e_fd = PCSrcE; e_fe = lw | PCSrcE; e_frz = 1'b0;
        end
    endtask

    task automatic tick();
        model_comb();
        @(posedge clk);
        if (rst) begin
            m_p = 0; m_err = 1'b0; m_cnt = '0;
        end else begin
            m_cnt = m_cnt + (e_sf ? 32'd1 : 32'd0);
            m_err = e_to;
            if (e_frz) m_p = m_p + 1;
            else       m_p = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE0 = 1'b0;
        PCSrcE = 1'b0; MemReqM = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, FreezeEMW} !== 9'b0000_00110) begin
            bad++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, FreezeEMW}, 9'b0000_00110);
        end
        total++;
        if (stall_cycles !== 32'd0 || mem_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_regs: got cnt=%0d err=%b expected cnt=0 err=0", stall_cycles, mem_err);
        end
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (FlushD !== 1'b0 || FlushE !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got FlushD=%b FlushE=%b expected 0 0", FlushD, FlushE);
        end
    endtask

    task automatic test_forward();
        idle_inputs();
        RdM = 5'd5; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1;
        #1;
        total++;
        if (ForwardAE !== 2'b10 || ForwardBE !== 2'b10) begin
            bad++;
            $display("FAIL fwd_m_priority: got A=%b B=%b expected 10 10", ForwardAE, ForwardBE);
        end
        RdM = 5'd0;
        #1;
        total++;
        if (ForwardAE !== 2'b01) begin
            bad++;
            $display("FAIL fwd_w: got %b expected 01", ForwardAE);
        end
        Rs2E = 5'd0; RdW = 5'd0;
        #1;
        total++;
        if (ForwardBE !== 2'b00) begin
            bad++;
            $display("FAIL fwd_x0: got %b expected 00", ForwardBE);
        end
        RdW = 5'd9; Rs1E = 5'd9; RegWriteW = 1'b0;
        #1;
        total++;
        if (ForwardAE !== 2'b00) begin
            bad++;
            $display("FAIL fwd_no_write: got %b expected 00", ForwardAE);
        end
        idle_inputs();
    endtask

    task automatic test_load_use();
        idle_inputs();
        ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7; Rs1D = 5'd3;
        #1;
        total++;
        if ({StallF, StallD, FlushD, FlushE, FreezeEMW} !== 5'b11010) begin
            bad++;
            $display("FAIL load_use: got %b expected 11010", {StallF, StallD, FlushD, FlushE, FreezeEMW});
        end
        tick();
        idle_inputs();
        #1;
        total++;
        if (stall_cycles !== 32'd1) begin
            bad++;
            $display("FAIL load_use_count: got %0d expected 1", stall_cycles);
        end
    endtask

    task automatic test_branch_load_use();
        idle_inputs();
        ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
        #1;
        total++;
        if ({StallF, StallD, FlushD, FlushE, FreezeEMW} !== 5'b11110) begin
            bad++;
            $display("FAIL branch_load_use: got %b expected 11110", {StallF, StallD, FlushD, FlushE, FreezeEMW});
        end
        tick();
        idle_inputs();
        PCSrcE = 1'b1;
        #1;
        total++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0011 || stall_cycles !== m_cnt) begin
            bad++;
            $display("FAIL branch_only: got %b cnt=%0d expected 0011 cnt=%0d",
                     {StallF, StallD, FlushD, FlushE}, stall_cycles, m_cnt);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_mem_wait();
        logic [CW-1:0] cnt0;
        idle_inputs();
        MemReqM = 1'b1; dmem_ready = 1'b1;
        #1;
        total++;
        if (FreezeEMW !== 1'b0 || StallF !== 1'b0) begin
            bad++;
            $display("FAIL ready_no_stall: got freeze=%b stallf=%b expected 0 0", FreezeEMW, StallF);
        end
        tick();
        cnt0 = m_cnt;
        dmem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            PCSrcE = (c == 1); ResultSrcE0 = (c == 2); RdE = 5'd4; Rs1D = 5'd4;
            #1;
            total++;
            if ({StallF, StallD, FlushD, FlushE, FreezeEMW} !== 5'b11001) begin
                bad++;
                $display("FAIL mem_wait_c%0d: got %b expected 11001", c, {StallF, StallD, FlushD, FlushE, FreezeEMW});
            end
            tick();
        end
        PCSrcE = 1'b0; ResultSrcE0 = 1'b0; dmem_ready = 1'b1;
        #1;
        total++;
        if (FreezeEMW !== 1'b0 || StallF !== 1'b0) begin
            bad++;
            $display("FAIL mem_release: got freeze=%b stallf=%b expected 0 0", FreezeEMW, StallF);
        end
        tick();
        MemReqM = 1'b0;
        #1;
        total++;
        if (stall_cycles !== cnt0 + 32'd3 || mem_err !== 1'b0) begin
            bad++;
            $display("FAIL mem_wait_count: got cnt=%0d err=%b expected cnt=%0d err=0",
                     stall_cycles, mem_err, cnt0 + 32'd3);
        end
    endtask

    task automatic test_timeout();
        idle_inputs();
        MemReqM = 1'b1; dmem_ready = 1'b0;
        for (int c = 1; c <= T; c++) begin
            #1;
            total++;
            if (FreezeEMW !== (c < T) || mem_err !== 1'b0) begin
                bad++;
                $display("FAIL timeout_c%0d: got freeze=%b err=%b expected freeze=%b err=0",
                         c, FreezeEMW, mem_err, (c < T));
            end
            tick();
        end
        MemReqM = 1'b0;
        #1;
        total++;
        if (mem_err !== 1'b1 || FreezeEMW !== 1'b0) begin
            bad++;
            $display("FAIL timeout_err: got err=%b freeze=%b expected 1 0", mem_err, FreezeEMW);
        end
        tick();
        total++;
        if (mem_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse: got err=%b expected 0", mem_err);
        end
    endtask

    task automatic test_reset_mid_wait();
        idle_inputs();
        MemReqM = 1'b1; dmem_ready = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        m_p = 0; m_err = 1'b0; m_cnt = '0;
        #1;
        total++;
        if ({ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, FreezeEMW} !== 9'b0000_00110 ||
            stall_cycles !== 32'd0 || mem_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_wait: got %b cnt=%0d err=%b expected 000000110 cnt=0 err=0",
                     {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, FreezeEMW}, stall_cycles, mem_err);
        end
        tick();
        rst = 1'b0;
        MemReqM = 1'b0;
        for (int c = 0; c < T + 1; c++) begin
            #1;
            total++;
            if (FreezeEMW !== 1'b0 || mem_err !== 1'b0) begin
                bad++;
                $display("FAIL after_reset_c%0d: got freeze=%b err=%b expected 0 0", c, FreezeEMW, mem_err);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            RegWriteM   = 1'($urandom_range(0, 1));
            RegWriteW   = 1'($urandom_range(0, 1));
            ResultSrcE0 = ($urandom_range(0, 3) == 0);
            PCSrcE      = ($urandom_range(0, 4) == 0);
            MemReqM     = ($urandom_range(0, 2) == 0);
            dmem_ready  = ($urandom_range(0, 3) == 0);
            #1;
            model_comb();
            total++;
            if ({ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, FreezeEMW} !==
                {e_fa, e_fb, e_sf, e_sd, e_fd, e_fe, e_frz}) begin
                bad++;
                $display("FAIL rand_comb_c%0d: got %b expected %b", c,
                         {ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, FreezeEMW},
                         {e_fa, e_fb, e_sf, e_sd, e_fd, e_fe, e_frz});
            end
            total++;
            if (mem_err !== m_err || stall_cycles !== m_cnt) begin
                bad++;
                $display("FAIL rand_regs_c%0d: got err=%b cnt=%0d expected err=%b cnt=%0d",
                         c, mem_err, stall_cycles, m_err, m_cnt);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        #1;
        rst = 1'b1;
        test_reset();
        test_forward();
        test_load_use();
        test_branch_load_use();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
